// File: rtl/grptrig_n_if.sv
// Signal bundle between a grptrig_n group trigger and the channel processors / readout.
// slave = trigger block side, master = sample source and trigger consumer side.
interface grptrig_n_if #(
  parameter int NCH    = 2,
  parameter int DW     = 16,
  parameter int SW     = 20,
  parameter int CWBITS = 4,
  parameter int DTBITS = 8
);
  logic        [NCH*DW-1:0] data;
  logic signed [DW-1:0]     ithr;
  logic signed [SW-1:0]     sthr;
  logic        [4:0]        mult;
  logic        [CWBITS-1:0] cwin;
  logic        [DTBITS-1:0] deadtime;
  logic        [NCH-1:0]    mask;
  logic                     inhibit;
  logic                     exttrig;
  logic                     trig;
  logic        [1:0]        trig_src;
  logic        [NCH-1:0]    hitmap;
  logic        [15:0]       trig_cnt;

  modport master (
    output data, ithr, sthr, mult, cwin, deadtime, mask, inhibit, exttrig,
    input  trig, trig_src, hitmap, trig_cnt
  );

  modport slave (
    input  data, ithr, sthr, mult, cwin, deadtime, mask, inhibit, exttrig,
    output trig, trig_src, hitmap, trig_cnt
  );
endinterface

// File: rtl/grptrig_n.sv
// N-channel group trigger: threshold hits, group sum, stretched-hit multiplicity and an
// external-trigger path feeding a fire / dead / re-arm sequencer with a saturating counter.
//
// state | meaning
// IDLE  | armed, waiting for cond_int or ext_edge while not inhibited
// FIRE  | one-clock trigger pulse; hitmap, trig_src and trig_cnt updated on entry
// DEAD  | dead counter running down, all triggers ignored
// REARM | waiting for cond_int to drop before re-arming
module grptrig_n #(
  parameter int NCH    = 2,
  parameter int DW     = 16,
  parameter int SW     = 20,
  parameter int CWBITS = 4,
  parameter int DTBITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  grptrig_n_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRE  = 2'd1,
    DEAD  = 2'd2,
    REARM = 2'd3
  } state_t;

  // stage 1
  logic        [NCH-1:0]    hit_d, hit_q;
  logic signed [SW-1:0]     sum_d, sum_q;

  // stage 2
  logic        [CWBITS-1:0] cnt_d [NCH];
  logic        [CWBITS-1:0] cnt_q [NCH];
  logic        [NCH-1:0]    str_d, str_q;
  logic signed [SW-1:0]     sum2_d, sum2_q;

  // stage 3
  logic        [4:0]        nstr;
  logic                     cond_d, cond_q;
  logic        [NCH-1:0]    str3_d, str3_q;

  // external path
  logic                     ext1_d, ext1_q;
  logic                     ext2_d, ext2_q;
  logic                     ext_edge;
  logic                     extd1_d, extd1_q;
  logic                     extd2_d, extd2_q;

  // sequencer
  state_t                   state_d, state_q;
  logic        [DTBITS-1:0] dead_d, dead_q;
  logic        [1:0]        trig_src_d, trig_src_q;
  logic        [NCH-1:0]    hitmap_d, hitmap_q;
  logic        [15:0]       trig_cnt_d, trig_cnt_q;

  function automatic logic signed [SW-1:0] sext(input logic [DW-1:0] v);
    return {{(SW-DW){v[DW-1]}}, v};
  endfunction

  always_comb begin
    hit_d = '0;
    sum_d = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!bus.mask[k]) begin
        hit_d[k] = $signed(bus.data[DW*k +: DW]) > bus.ithr;
        sum_d    = sum_d + sext(bus.data[DW*k +: DW]);
      end
    end
  end

  // A fresh hit reloads the stretcher; str covers the hit clock plus cwin clocks after it.
  always_comb begin
    str_d  = '0;
    sum2_d = sum_q;
    for (int k = 0; k < NCH; k++) begin
      cnt_d[k] = cnt_q[k];
      str_d[k] = hit_q[k] || (cnt_q[k] != '0);
      if (hit_q[k]) begin
        cnt_d[k] = bus.cwin;
      end else if (cnt_q[k] != '0) begin
        cnt_d[k] = cnt_q[k] - CWBITS'(1);
      end
    end
  end

  always_comb begin
    nstr = '0;
    for (int k = 0; k < NCH; k++) begin
      nstr = nstr + 5'(str_q[k]);
    end
    cond_d = ((bus.mult == 5'd0) || (nstr >= bus.mult)) && (sum2_q > bus.sthr);
    str3_d = str_q;
  end

  // Two extra flops on the edge detector line it up with cond_q.
  always_comb begin
    ext1_d   = bus.exttrig;
    ext2_d   = ext1_q;
    ext_edge = ext1_q && !ext2_q;
    extd1_d  = ext_edge;
    extd2_d  = extd1_q;
  end

  always_comb begin
    state_d    = state_q;
    dead_d     = dead_q;
    trig_src_d = trig_src_q;
    hitmap_d   = hitmap_q;
    trig_cnt_d = trig_cnt_q;
    case (state_q)
      IDLE: begin
        if (!bus.inhibit && (cond_q || extd2_q)) begin
          state_d    = FIRE;
          trig_src_d = {extd2_q, cond_q};
          hitmap_d   = str3_q;
          dead_d     = bus.deadtime;
          if (trig_cnt_q != 16'hFFFF) begin
            trig_cnt_d = trig_cnt_q + 16'd1;
          end
        end
      end
      FIRE, DEAD: begin
        if (dead_q == '0) begin
          state_d = REARM;
        end else begin
          state_d = DEAD;
          dead_d  = dead_q - DTBITS'(1);
        end
      end
      REARM: begin
        if (!cond_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q      <= '0;
      sum_q      <= '0;
      str_q      <= '0;
      sum2_q     <= '0;
      cond_q     <= 1'b0;
      str3_q     <= '0;
      ext1_q     <= 1'b0;
      ext2_q     <= 1'b0;
      extd1_q    <= 1'b0;
      extd2_q    <= 1'b0;
      state_q    <= IDLE;
      dead_q     <= '0;
      trig_src_q <= '0;
      hitmap_q   <= '0;
      trig_cnt_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      hit_q      <= hit_d;
      sum_q      <= sum_d;
      str_q      <= str_d;
      sum2_q     <= sum2_d;
      cond_q     <= cond_d;
      str3_q     <= str3_d;
      ext1_q     <= ext1_d;
      ext2_q     <= ext2_d;
      extd1_q    <= extd1_d;
      extd2_q    <= extd2_d;
      state_q    <= state_d;
      dead_q     <= dead_d;
      trig_src_q <= trig_src_d;
      hitmap_q   <= hitmap_d;
      trig_cnt_q <= trig_cnt_d;
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign bus.trig     = (state_q == FIRE);
  assign bus.trig_src = trig_src_q;
  assign bus.hitmap   = hitmap_q;
  assign bus.trig_cnt = trig_cnt_q;

endmodule

// File: tb/tb_grptrig_n.sv
// Bench for grptrig_n: a 2-channel and a 4-channel instance, vector table plus corner sequences,
// with expected triggers queued at stimulus time and matched when trig appears.
module tb_grptrig_n;

  logic clk = 1'b0;
  logic rst2, rst4;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  grptrig_n_if #(.NCH(2)) if2 ();
  grptrig_n_if #(.NCH(4)) if4 ();

  grptrig_n #(.NCH(2)) u2 (.clk(clk), .reset(rst2), .bus(if2.slave));
  grptrig_n #(.NCH(4)) u4 (.clk(clk), .reset(rst4), .bus(if4.slave));

  typedef struct {
    int          due;
    logic [1:0]  src;
    logic [15:0] hm;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q2[$];
  exp_t        q4[$];
  exp_t        e2, e4;
  logic [15:0] exp_cnt2 = 16'd0;
  logic [15:0] exp_cnt4 = 16'd0;

  typedef struct {
    bit                 use4;
    logic signed [15:0] c0, c1, c2, c3;
    logic        [3:0]  mask;
    logic        [4:0]  mult;
    logic signed [15:0] ithr;
    logic signed [19:0] sthr;
    bit                 fire;
    logic        [1:0]  src;
    logic        [3:0]  hm;
  } vec_t;

  localparam int NV = 14;
  vec_t vt[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic push2(input logic [1:0] src, input logic [3:0] hm);
    if (exp_cnt2 != 16'hFFFF) exp_cnt2 = exp_cnt2 + 16'd1;
    q2.push_back('{cyc + 4, src, {12'd0, hm}, exp_cnt2});
  endtask

  task automatic push4(input logic [1:0] src, input logic [3:0] hm);
    if (exp_cnt4 != 16'hFFFF) exp_cnt4 = exp_cnt4 + 16'd1;
    q4.push_back('{cyc + 4, src, {12'd0, hm}, exp_cnt4});
  endtask

  always @(negedge clk) begin
    if (if2.trig === 1'b1) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u2_unexpected_trig actual=1 required=0 cyc=%0d", cyc);
      end else begin
        e2 = q2.pop_front();
        chk("u2_trig_cycle", 32'(cyc), 32'(e2.due));
        chk("u2_trig_src", 32'(if2.trig_src), 32'(e2.src));
        chk("u2_hitmap", 32'(if2.hitmap), 32'(e2.hm));
        chk("u2_trig_cnt", 32'(if2.trig_cnt), 32'(e2.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (if4.trig === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u4_unexpected_trig actual=1 required=0 cyc=%0d", cyc);
      end else begin
        e4 = q4.pop_front();
        chk("u4_trig_cycle", 32'(cyc), 32'(e4.due));
        chk("u4_trig_src", 32'(if4.trig_src), 32'(e4.src));
        chk("u4_hitmap", 32'(if4.hitmap), 32'(e4.hm));
        chk("u4_trig_cnt", 32'(if4.trig_cnt), 32'(e4.cnt));
      end
    end
  end

  task automatic quiet2();
    if2.data = '0;
  endtask

  task automatic quiet4();
    if4.data = {4{16'shFC18}};
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    if (v.use4) begin
      if4.ithr = v.ithr;
      if4.sthr = v.sthr;
      if4.mult = v.mult;
      if4.mask = v.mask;
      if4.data = {v.c3, v.c2, v.c1, v.c0};
      if (v.fire) push4(v.src, v.hm);
      @(negedge clk);
      quiet4();
    end else begin
      if2.ithr = v.ithr;
      if2.sthr = v.sthr;
      if2.mult = v.mult;
      if2.mask = v.mask[1:0];
      if2.data = {v.c1, v.c0};
      if (v.fire) push2(v.src, v.hm);
      @(negedge clk);
      quiet2();
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic ext4_pulse(input bit expect_fire);
    @(negedge clk);
    if4.exttrig = 1'b1;
    if (expect_fire) push4(2'b10, 4'b0000);
    repeat (2) @(negedge clk);
    if4.exttrig = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{0, 120, 120, 0, 0, 4'b0000, 5'd2, 100, 150, 1, 2'b01, 4'b0011};
    vt[1]  = '{0, 120, 0, 0, 0, 4'b0000, 5'd2, 100, 150, 0, 2'b00, 4'b0000};
    vt[2]  = '{0, 100, 200, 0, 0, 4'b0000, 5'd2, 100, 150, 0, 2'b00, 4'b0000};
    vt[3]  = '{0, 101, 101, 0, 0, 4'b0000, 5'd2, 100, 150, 1, 2'b01, 4'b0011};
    vt[4]  = '{0, 120, 120, 0, 0, 4'b0001, 5'd2, 100, 150, 0, 2'b00, 4'b0000};
    vt[5]  = '{0, 150, 0, 0, 0, 4'b0000, 5'd0, 100, 150, 0, 2'b00, 4'b0000};
    vt[6]  = '{0, 151, 0, 0, 0, 4'b0000, 5'd0, 100, 150, 1, 2'b01, 4'b0001};
    vt[7]  = '{0, 120, 120, 0, 0, 4'b0000, 5'd3, 100, 150, 0, 2'b00, 4'b0000};
    vt[8]  = '{0, 120, -50, 0, 0, 4'b0000, 5'd1, 100, 150, 0, 2'b00, 4'b0000};
    vt[9]  = '{1, -3, -3, -10, -10, 4'b0100, 5'd1, -5, -20, 1, 2'b01, 4'b0011};
    vt[10] = '{1, -3, -3, -10, -10, 4'b0000, 5'd1, -5, -20, 0, 2'b00, 4'b0000};
    vt[11] = '{1, -3, -3, -10, -10, 4'b0100, 5'd3, -5, -20, 0, 2'b00, 4'b0000};
    vt[12] = '{1, -3, -3, -10, -10, 4'b1100, 5'd0, -5, -20, 1, 2'b01, 4'b0011};
    vt[13] = '{1, -6, -4, -5, -5, 4'b0000, 5'd1, -5, -30, 1, 2'b01, 4'b0010};

    rst2 = 1'b1;
    rst4 = 1'b1;
    quiet2();
    if2.ithr = 16'sd100; if2.sthr = 20'sd150; if2.mult = 5'd2; if2.cwin = '0;
    if2.deadtime = 8'd4; if2.mask = '0; if2.inhibit = 1'b0; if2.exttrig = 1'b0;
    quiet4();
    if4.ithr = -16'sd5; if4.sthr = -20'sd20; if4.mult = 5'd1; if4.cwin = '0;
    if4.deadtime = 8'd4; if4.mask = '0; if4.inhibit = 1'b0; if4.exttrig = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_u2_trig", 32'(if2.trig), 32'd0);
    chk("rst_u2_src", 32'(if2.trig_src), 32'd0);
    chk("rst_u2_hitmap", 32'(if2.hitmap), 32'd0);
    chk("rst_u2_cnt", 32'(if2.trig_cnt), 32'd0);
    chk("rst_u4_hitmap", 32'(if4.hitmap), 32'd0);
    chk("rst_u4_cnt", 32'(if4.trig_cnt), 32'd0);
    rst2 = 1'b0;
    rst4 = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < NV; i++) apply_vec(vt[i]);

    // u2 defaults for the sequences below
    if2.ithr = 16'sd100; if2.sthr = 20'sd150; if2.mult = 5'd2; if2.mask = '0;

    // stretched coincidence: ch1 two clocks after ch0
    if2.sthr = 20'sd50;
    if2.cwin = 4'd3;
    @(negedge clk); if2.data = {16'sd0, 16'sd120};
    @(negedge clk); quiet2();
    @(negedge clk); if2.data = {16'sd120, 16'sd0}; push2(2'b01, 4'b0011);
    @(negedge clk); quiet2();
    repeat (14) @(negedge clk);
    if2.cwin = 4'd1;
    @(negedge clk); if2.data = {16'sd0, 16'sd120};
    @(negedge clk); quiet2();
    @(negedge clk); if2.data = {16'sd120, 16'sd0};
    @(negedge clk); quiet2();
    repeat (14) @(negedge clk);
    if2.cwin = '0;
    if2.sthr = 20'sd150;

    // condition held for 20 clocks, then dropped and restored
    @(negedge clk); if2.data = {16'sd120, 16'sd120}; push2(2'b01, 4'b0011);
    repeat (20) @(negedge clk);
    quiet2();
    repeat (4) @(negedge clk);
    if2.data = {16'sd120, 16'sd120}; push2(2'b01, 4'b0011);
    @(negedge clk); quiet2();
    repeat (14) @(negedge clk);

    // external edge, then simultaneous with the internal condition
    @(negedge clk); if2.exttrig = 1'b1; push2(2'b10, 4'b0000);
    repeat (3) @(negedge clk); if2.exttrig = 1'b0;
    repeat (12) @(negedge clk);
    @(negedge clk); if2.exttrig = 1'b1; if2.data = {16'sd120, 16'sd120}; push2(2'b11, 4'b0011);
    @(negedge clk); quiet2();
    repeat (2) @(negedge clk); if2.exttrig = 1'b0;
    repeat (12) @(negedge clk);

    // inhibited external edge is lost
    if2.inhibit = 1'b1;
    @(negedge clk); if2.exttrig = 1'b1;
    repeat (3) @(negedge clk); if2.exttrig = 1'b0;
    repeat (8) @(negedge clk);
    if2.inhibit = 1'b0;
    repeat (6) @(negedge clk);
    chk("inhibit_cnt_unchanged", 32'(if2.trig_cnt), 32'(exp_cnt2));

    // reset while dead
    if2.deadtime = 8'd20;
    @(negedge clk); if2.data = {16'sd120, 16'sd120}; push2(2'b01, 4'b0011);
    @(negedge clk); quiet2();
    repeat (6) @(negedge clk);
    rst2 = 1'b1;
    if2.data = {16'sd120, 16'sd120};
    @(negedge clk);
    chk("dead_rst_trig", 32'(if2.trig), 32'd0);
    chk("dead_rst_src", 32'(if2.trig_src), 32'd0);
    chk("dead_rst_hitmap", 32'(if2.hitmap), 32'd0);
    chk("dead_rst_cnt", 32'(if2.trig_cnt), 32'd0);
    rst2 = 1'b0;
    exp_cnt2 = 16'd0;
    push2(2'b01, 4'b0011);
    repeat (6) @(negedge clk);
    quiet2();
    repeat (30) @(negedge clk);
    if2.deadtime = 8'd4;

    // counter saturation on u4, preloaded near the top
    @(negedge clk);
    force u4.trig_cnt_q = 16'hFFFD;
    @(negedge clk);
    release u4.trig_cnt_q;
    exp_cnt4 = 16'hFFFD;
    repeat (4) ext4_pulse(1'b1);

    repeat (10) @(negedge clk);
    chk("u2_missed_trigs", 32'(q2.size()), 32'd0);
    chk("u4_missed_trigs", 32'(q4.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
